iob_rx_filter: RTL and testbench
================================

Name: iob_rx_filter

Overview:
- Input-side companion to the tri-state pad driver: the receive path for a shared bidirectional pad bus.
- Synchronises WIDTH pad inputs into clock domain C and rejects glitches with a per-bit stability filter.
- Blanks reception while our own driver is enabled and for a turnaround window after release.
- Produces filtered levels plus single-cycle rise/fall strobes for fabric logic.

Parameters:
- WIDTH, 8: number of pad bits received.
- SYNC_STAGES, 2: synchroniser flops per bit; minimum 2.
- FILTER_CYCLES, 4: consecutive mismatching samples required before O changes; minimum 1.
- TURNAROUND, 2: cycles ignored after T goes 0->1 (bus settling); 0 is allowed.

Ports:
- C  input  1  clock.
- R  input  1  reset, synchronous, active-high.
- I  input  WIDTH  raw pad input, asynchronous to C.
- T  input  1  our pad driver's tristate control, same polarity as the driver: 0 = we drive, 1 = released. Synchronous to C.
- CE  input  1  clock enable for filter and state logic.
- O  output  WIDTH  filtered pad level.
- O_VALID  output  1  high while in LISTEN.
- RISE  output  WIDTH  one-cycle pulse per bit on a filtered 0->1 change of O.
- FALL  output  WIDTH  one-cycle pulse per bit on a filtered 1->0 change of O.

Behaviour:
- Reset (R=1 at an edge):
  - Sync chain, O, RISE, FALL and filter counters are cleared to 0.
  - O_VALID = 0.
  - State = TURN with the turnaround counter loaded to TURNAROUND.
- Synchroniser:
  - Always runs, independent of CE and state.
  - s = I delayed by SYNC_STAGES edges.
- States:
  - DRIVE: entered at the next edge whenever T=0, from any state, regardless of CE.
  - TURN: entered from DRIVE when T=1. Counts TURNAROUND CE-qualified cycles, then moves to LISTEN. With TURNAROUND=0, DRIVE moves directly to LISTEN.
  - LISTEN: normal reception.
- O_VALID is registered and equals 1 exactly when state is LISTEN.
- In DRIVE and TURN:
  - Filter counters are held at 0.
  - O holds its last value.
  - RISE and FALL are 0.
- Filter, per bit, in LISTEN with CE=1, at each edge:
  - If s == O: counter <= 0.
  - If s != O and counter == FILTER_CYCLES-1: O <= s, counter <= 0, and RISE or FALL pulses for the following cycle.
  - Otherwise: counter increments.
- Counter width is clog2(FILTER_CYCLES) bits, minimum 1. The counter never wraps, because it clears at FILTER_CYCLES-1.
- CE=0:
  - Filter counters, O and the turnaround count freeze.
  - RISE and FALL are forced to 0.
  - The DRIVE transition on T=0 still occurs.
- Latency: a pad change set up before edge 0 appears on O after edge SYNC_STAGES+FILTER_CYCLES-1, with CE=1 and no glitches.
- A glitch shorter than FILTER_CYCLES synced samples never changes O.
- Simultaneous events:
  - T=0 in the same cycle a filter would qualify: DRIVE wins, and O does not change.
  - R=1 overrides everything.
- On re-entering LISTEN, O still holds its pre-drive value. A differing bus level then produces a normal filtered edge after FILTER_CYCLES samples.
- RISE and FALL are registered, never both high on the same bit, and last exactly one cycle.

Decomposition:
- Package iob_rx_pkg contains:
  - state enum rx_state_t {DRIVE, TURN, LISTEN};
  - function clog2_min1 for counter widths;
  - default parameter constants.
- Sub-module iob_rx_bitfilter holds the per-bit synchroniser, stability counter, O bit and edge pulses. It takes a listen-enable input and is instantiated WIDTH times.
- The top level holds the state machine and turnaround counter.

Test Plan:
- Reset then release:
  - Stimulus: R high 1 cycle, T=1, CE=1, TURNAROUND=2.
  - Required: O_VALID=0 after reset; O_VALID=1 after the 2nd following edge; O=0x00.
- Clean edge latency:
  - Stimulus: in LISTEN, I 0x00->0xA5 before edge 0 (SYNC_STAGES=2, FILTER_CYCLES=4).
  - Required: O=0xA5 after edge 5; RISE=0xA5 for exactly that one cycle; FALL=0.
- Glitch rejection:
  - Stimulus: bit 0 pulses high for 3 cycles, then for 4 cycles.
  - Required: no change on the 3-cycle pulse; the 4-cycle pulse gives O[0]=1 then 0, with one RISE and one FALL pulse.
- Drive blanking:
  - Stimulus: T=0 while I toggles 0x00<->0xFF.
  - Required: O_VALID=0; O holds its value; RISE and FALL stay 0.
  - Then T=1 with I=0xFF: O_VALID=1 after 2 cycles, then O=0xFF 4 samples later with RISE=0xFF.
- CE freeze:
  - Stimulus: CE=0 mid-count after 2 mismatches, held 10 cycles, then CE=1.
  - Required: O unchanged while CE=0; O updates after 2 further CE cycles.
- Reset mid-operation:
  - Stimulus: R asserted in LISTEN with the counter at 3.
  - Required: O=0, O_VALID=0, counters 0, state TURN on the next cycle.

Source files
------------

// File: rtl/iob_rx_pkg.sv
// Shared types and constants for the bidirectional pad receive path.
package iob_rx_pkg;

  // Receive-side view of the pad bus ownership.
  typedef enum logic [1:0] {
    DRIVE  = 2'd0,
    TURN   = 2'd1,
    LISTEN = 2'd2
  } rx_state_t;

  localparam int DEF_WIDTH         = 8;
  localparam int DEF_SYNC_STAGES   = 2;
  localparam int DEF_FILTER_CYCLES = 4;
  localparam int DEF_TURNAROUND    = 2;

  // Bits needed to hold values 0..value-1, never less than one bit.
  function automatic int clog2_min1(input int value);
    int w;
    w = (value <= 1) ? 1 : $clog2(value);
    return w;
  endfunction

endpackage

// File: rtl/iob_rx_bitfilter.sv
// One pad bit: synchroniser, stability counter, filtered level and edge strobes.
module iob_rx_bitfilter
  import iob_rx_pkg::*;
#(
  parameter int SYNC_STAGES   = DEF_SYNC_STAGES,
  parameter int FILTER_CYCLES = DEF_FILTER_CYCLES
) (
  input  logic clk,
  input  logic srst,
  input  logic ce_i,
  input  logic listen_i,
  input  logic pad_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  localparam int CW = clog2_min1(FILTER_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(FILTER_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   level_q, level_d;
  logic                   rise_q, rise_d;
  logic                   fall_q, fall_d;

  assign s = sync_q[SYNC_STAGES-1];

  // Synchroniser chain runs every cycle, independent of CE and bus state.
  always_ff @(posedge clk) begin
    if (srst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], pad_i};
    end
  end

  // Stability filter: level follows s only after FILTER_CYCLES consecutive mismatches.
  always_comb begin
    cnt_d   = cnt_q;
    level_d = level_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    if (!listen_i) begin
      cnt_d = '0;
    end else if (ce_i) begin
      if (s == level_q) begin
        cnt_d = '0;
      end else if (cnt_q == CNT_LAST) begin
        level_d = s;
        cnt_d   = '0;
        rise_d  = s;
        fall_d  = ~s;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // Register filter state and the one-cycle edge strobes.
  always_ff @(posedge clk) begin
    if (srst) begin
      cnt_q   <= '0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      level_q <= level_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  assign level_o = level_q;
  assign rise_o  = rise_q;
  assign fall_o  = fall_q;

endmodule

// File: rtl/iob_rx_filter.sv
// Receive path for a shared pad bus: blanks while we drive, then filters each bit.
module iob_rx_filter
  import iob_rx_pkg::*;
#(
  parameter int WIDTH         = DEF_WIDTH,
  parameter int SYNC_STAGES   = DEF_SYNC_STAGES,
  parameter int FILTER_CYCLES = DEF_FILTER_CYCLES,
  parameter int TURNAROUND    = DEF_TURNAROUND
) (
  input  logic             C,
  input  logic             R,
  input  logic [WIDTH-1:0] I,
  input  logic             T,
  input  logic             CE,
  output logic [WIDTH-1:0] O,
  output logic             O_VALID,
  output logic [WIDTH-1:0] RISE,
  output logic [WIDTH-1:0] FALL
);

  localparam int TW = clog2_min1(TURNAROUND + 1);
  localparam logic [TW-1:0] TURN_LOAD = TW'(TURNAROUND);
  localparam logic [TW-1:0] TURN_ONE  = TW'(1);

  rx_state_t     state_q, state_d;
  logic [TW-1:0] turn_cnt_q, turn_cnt_d;
  logic          o_valid_q;
  logic          listen;

  // Next-state: T=0 always forces DRIVE; the turnaround count advances only on CE.
  always_comb begin
    state_d    = state_q;
    turn_cnt_d = turn_cnt_q;
    if (!T) begin
      state_d = DRIVE;
    end else begin
      case (state_q)
        DRIVE: begin
          if (TURNAROUND == 0) begin
            state_d = LISTEN;
          end else begin
            state_d    = TURN;
            turn_cnt_d = TURN_LOAD;
          end
        end
        TURN: begin
          if (CE) begin
            if (turn_cnt_q <= TURN_ONE) begin
              state_d    = LISTEN;
              turn_cnt_d = '0;
            end else begin
              turn_cnt_d = turn_cnt_q - 1'b1;
            end
          end
        end
        LISTEN: begin
          state_d = LISTEN;
        end
        default: begin
          state_d    = TURN;
          turn_cnt_d = TURN_LOAD;
        end
      endcase
    end
  end

  // State register with O_VALID registered alongside so it tracks LISTEN exactly.
  always_ff @(posedge C) begin
    if (R) begin
      state_q    <= TURN;
      turn_cnt_q <= TURN_LOAD;
      o_valid_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      turn_cnt_q <= turn_cnt_d;
      o_valid_q  <= (state_d == LISTEN);
    end
  end

  // Gate with T so a bit cannot qualify on the same edge that enters DRIVE.
  assign listen  = (state_q == LISTEN) && T;
  assign O_VALID = o_valid_q;

  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
      iob_rx_bitfilter #(
        .SYNC_STAGES  (SYNC_STAGES),
        .FILTER_CYCLES(FILTER_CYCLES)
      ) u_bit (
        .clk     (C),
        .srst    (R),
        .ce_i    (CE),
        .listen_i(listen),
        .pad_i   (I[gi]),
        .level_o (O[gi]),
        .rise_o  (RISE[gi]),
        .fall_o  (FALL[gi])
      );
    end
  endgenerate

endmodule

// File: tb/tb_iob_rx_filter.sv
// Scoreboard bench: stimulus queues expected output events, a negedge monitor checks them.
module tb_iob_rx_filter;

  typedef struct {
    int         cyc;
    logic [7:0] o;
    logic       v;
    logic [7:0] r;
    logic [7:0] f;
  } ev_t;

  logic       clk;
  logic       R;
  logic [7:0] I;
  logic       T;
  logic       CE;
  logic [7:0] O;
  logic       O_VALID;
  logic [7:0] RISE;
  logic [7:0] FALL;

  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;
  bit   mon_en = 0;
  logic       prev_v;
  logic [7:0] prev_o;
  ev_t  exp_q[$];

  iob_rx_filter #(
    .WIDTH        (8),
    .SYNC_STAGES  (2),
    .FILTER_CYCLES(4),
    .TURNAROUND   (2)
  ) dut (
    .C      (clk),
    .R      (R),
    .I      (I),
    .T      (T),
    .CE     (CE),
    .O      (O),
    .O_VALID(O_VALID),
    .RISE   (RISE),
    .FALL   (FALL)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: any strobe, O change or O_VALID change is an output event to match.
  always @(negedge clk) begin
    ev_t e;
    if (mon_en) begin
      if (RISE != 8'h00 || FALL != 8'h00 || O_VALID !== prev_v || O !== prev_o) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_event cyc=%0d actual O=%h O_VALID=%b RISE=%h FALL=%h required none",
                   cyc, O, O_VALID, RISE, FALL);
        end else begin
          e = exp_q.pop_front();
          if (e.cyc != cyc || e.o !== O || e.v !== O_VALID || e.r !== RISE || e.f !== FALL) begin
            errors++;
            $display("FAIL event actual cyc=%0d O=%h V=%b RISE=%h FALL=%h required cyc=%0d O=%h V=%b RISE=%h FALL=%h",
                     cyc, O, O_VALID, RISE, FALL, e.cyc, e.o, e.v, e.r, e.f);
          end else begin
            $display("event ok cyc=%0d O=%h V=%b RISE=%h FALL=%h", cyc, O, O_VALID, RISE, FALL);
          end
        end
      end
    end
    prev_v = O_VALID;
    prev_o = O;
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push(input int dc, input logic [7:0] o, input logic v,
                      input logic [7:0] r, input logic [7:0] f);
    ev_t e;
    e.cyc = cyc + dc;
    e.o   = o;
    e.v   = v;
    e.r   = r;
    e.f   = f;
    exp_q.push_back(e);
  endtask

  task automatic check8(input string name, input logic [7:0] act, input logic [7:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end else begin
      $display("check ok %s value=%h", name, act);
    end
  endtask

  initial begin
    R  = 1'b1;
    I  = 8'h00;
    T  = 1'b1;
    CE = 1'b1;
    step(2);

    // Reset state
    check8("reset_O", O, 8'h00);
    check8("reset_O_VALID", {7'd0, O_VALID}, 8'h00);
    check8("reset_RISE", RISE, 8'h00);
    check8("reset_FALL", FALL, 8'h00);

    // Release: two TURN cycles then LISTEN
    R = 1'b0;
    mon_en = 1;
    push(2, 8'h00, 1'b1, 8'h00, 8'h00);
    step(3);
    check8("listen_O_VALID", {7'd0, O_VALID}, 8'h01);
    check8("listen_O", O, 8'h00);

    // Clean edge: O after edge SYNC+FILTER-1
    I = 8'hA5;
    push(6, 8'hA5, 1'b1, 8'hA5, 8'h00);
    step(8);

    // Drop bit 0 to set up glitch tests
    I = 8'hA4;
    push(6, 8'hA4, 1'b1, 8'h00, 8'h01);
    step(8);

    // 3-cycle glitch: rejected
    I = 8'hA5;
    step(3);
    I = 8'hA4;
    step(8);
    check8("glitch3_O", O, 8'hA4);

    // 4-cycle pulse: passes through as rise then fall
    I = 8'hA5;
    push(6, 8'hA5, 1'b1, 8'h01, 8'h00);
    push(10, 8'hA4, 1'b1, 8'h00, 8'h01);
    step(4);
    I = 8'hA4;
    step(10);

    // Bring O to 0x00 before drive blanking
    I = 8'h00;
    push(6, 8'h00, 1'b1, 8'h00, 8'hA4);
    step(8);

    // Drive blanking with toggling bus
    T = 1'b0;
    push(1, 8'h00, 1'b0, 8'h00, 8'h00);
    for (int i = 0; i < 8; i++) begin
      I = (i % 2 == 0) ? 8'hFF : 8'h00;
      step(1);
    end
    check8("drive_O", O, 8'h00);
    check8("drive_O_VALID", {7'd0, O_VALID}, 8'h00);

    // Release: TURN for 2 cycles, then 4 samples to a filtered rise
    I = 8'hFF;
    T = 1'b1;
    push(3, 8'h00, 1'b1, 8'h00, 8'h00);
    push(7, 8'hFF, 1'b1, 8'hFF, 8'h00);
    step(10);

    // CE freeze after 2 mismatches
    I = 8'h00;
    step(4);
    CE = 1'b0;
    step(10);
    check8("ce_freeze_O", O, 8'hFF);
    CE = 1'b1;
    push(2, 8'h00, 1'b1, 8'h00, 8'hFF);
    step(6);

    // Reset with the counter at 3
    I = 8'hFF;
    step(5);
    R = 1'b1;
    push(1, 8'h00, 1'b0, 8'h00, 8'h00);
    step(1);
    check8("midreset_O", O, 8'h00);
    check8("midreset_RISE", RISE, 8'h00);
    R = 1'b0;
    push(2, 8'h00, 1'b1, 8'h00, 8'h00);
    push(6, 8'hFF, 1'b1, 8'hFF, 8'h00);
    step(10);

    // All expected events must have been seen
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL missing_events actual_pending=%0d required=0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
